regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Shares the single register-file write port among NUM_REQ writeback sources
//   (ALU, load unit, multiplier, ...) using round-robin arbitration.
//   Drives the 5-bit write select and enable that feed the 5-to-32 write decoder
//   (decoder32 sel/en), plus registered write data.
//   Sits between the execute/writeback units and the register file.
// PARAMETERS
//   NUM_REQ   4    number of writeback requesters (2..8)
//   DATA_W    64   write data width
//   ADDR_W    5    register address width; fixed by the 32-entry file
//   ZERO_REG  31   hard-wired zero register; writes to it are accepted and dropped
// PORTS
//   clk        in   1                 clock, rising edge
//   rst_n      in   1                 asynchronous reset, active low
//   wb_stall   in   1                 1 = grant nothing this cycle (regfile busy)
//   req_valid  in   NUM_REQ           requester i has a write pending
//   req_addr   in   NUM_REQ x ADDR_W  destination register per requester
//   req_data   in   NUM_REQ x DATA_W  write data per requester
//   req_ready  out  NUM_REQ           one-hot grant; the transfer happens on valid & ready
//   wr_en      out  1                 write enable to the decoder en input
//   wr_sel     out  ADDR_W            write select to the decoder sel input
//   wr_data    out  DATA_W            write data to the regfile
// BEHAVIOUR
//   - Reset (rst_n=0, asynchronous):
//     - wr_en=0, wr_sel=0, wr_data=0.
//     - Round-robin pointer rr_ptr=0.
//     - Any accepted but not yet written transfer is discarded.
//   - req_ready is combinational from req_valid, rr_ptr and wb_stall.
//     - At most one bit is set.
//     - All bits are 0 when wb_stall=1 or no requester is valid.
//   - Grant rule: first valid requester scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//   - On a transfer by requester g: rr_ptr <= (g+1) mod NUM_REQ at the clock edge.
//     Otherwise rr_ptr holds.
//   - Requesters hold valid, addr and data stable until accepted.
//     Dropping valid before acceptance is illegal; the bench asserts this.
//   - Latency: a transfer accepted at edge k drives wr_en/wr_sel/wr_data for exactly
//     the cycle after edge k.
//     - Single-cycle pulse; wr_en is 0 in any cycle with no transfer at the prior edge.
//     - Throughput is one write per cycle.
//   - Zero register: a transfer with addr==ZERO_REG
//     - completes the handshake and advances rr_ptr;
//     - leaves wr_en=0 the next cycle, with wr_sel/wr_data holding their previous values.
//   - wb_stall=1: no grant, rr_ptr holds, wr_en=0 on the next cycle.
//   - Fairness: with wb_stall=0, a continuously valid requester is granted within
//     NUM_REQ cycles.
//   - Two requesters targeting the same register in consecutive grants: both writes
//     issue in grant order. No merging and no hazard checks; ordering belongs upstream.
//   - Reset mid-stream: the output drops the same cycle. After release, arbitration
//     restarts from requester 0.
// STRUCTURE
//   - regfile_pkg: ADDR_W, NUM_REGS=32, ZERO_REG localparams; wb_req_t typedef
//     struct {addr, data}.
//   - Sub-module rr_arbiter #(N): combinational rotate / priority-encode / unrotate,
//     giving a one-hot grant plus its index.
//   - Top level: rr_ptr register, mux of req_addr/req_data by grant index,
//     output register stage.
// TESTING
//   1. Reset: rst_n=0 with all valid=1 -> req_ready=0, wr_en=0, wr_sel=0; after release
//      the first grant is req0.
//   2. Single source: req2 valid, addr=5, data=0xABCD -> ready[2]=1 in the same cycle;
//      the next cycle wr_en=1, wr_sel=5, wr_data=0xABCD; decoder out[5]=1 only.
//   3. All four valid every cycle, wb_stall=0 -> grant order 0,1,2,3,0,...; wr_en=1 on
//      every cycle; each requester gets exactly 1 of every 4 grants.
//   4. req1 addr=31, req3 addr=7, both valid -> req1 granted first and wr_en=0 the
//      next cycle; then req3 granted and wr_en=1 with wr_sel=7.
//   5. All valid with wb_stall=1 for 3 cycles -> req_ready=0, wr_en=0, rr_ptr unchanged;
//      on release the grant resumes at the held pointer.
//   6. Assert rst_n=0 in the cycle after a grant -> wr_en drops without waiting for a
//      clock edge; no write occurs; post-reset grant order restarts at 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback request record used by the
// writeback arbiter.
package regfile_pkg;

    localparam int ADDR_W    = 5;
    localparam int NUM_REGS  = 32;
    localparam int ZERO_REG  = 31;
    localparam int WB_DATA_W = 64;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [WB_DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests so the pointer sits at bit 0,
// pick the lowest set bit, then rotate the winner back to an absolute index.
module rr_arbiter #(
    parameter int  N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [IDX_W-1:0] rot_idx;
    logic [IDX_W:0]   idx_sum;

    assign req_dbl = {req, req};
    assign req_rot = req_dbl[ptr +: N];

    always_comb begin
        rot_idx     = '0;
        grant_valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                rot_idx     = IDX_W'(i);
                grant_valid = 1'b1;
            end
        end
    end

    // Modulo-N add; N need not be a power of two.
    assign idx_sum   = {1'b0, ptr} + {1'b0, rot_idx};
    assign grant_idx = (idx_sum >= (IDX_W+1)'(N)) ? IDX_W'(idx_sum - (IDX_W+1)'(N))
                                                  : IDX_W'(idx_sum);

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_grant
            assign grant[gi] = grant_valid && (grant_idx == IDX_W'(gi));
        end
    endgenerate

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin sharing of the single register-file write port among NUM_REQ
// writeback sources, with a registered select/enable/data stage (DATA_W up to 64).
module regfile_wb_arbiter
    import regfile_pkg::wb_req_t;
#(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 64,
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wb_stall,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           wr_en,
    output logic [ADDR_W-1:0]              wr_sel,
    output logic [DATA_W-1:0]              wr_data
);

    localparam int PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0]   rr_ptr_reg;
    logic [PTR_W-1:0]   rr_ptr_next;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]   grant_idx;
    logic               grant_valid;
    logic               drop_write;
    wb_req_t            sel_req;

    logic               wr_en_reg;
    logic [ADDR_W-1:0]  wr_sel_reg;
    logic [DATA_W-1:0]  wr_data_reg;

    // Ready is suppressed while in reset so nothing looks accepted that will be lost.
    assign arb_req = (wb_stall || !rst_n) ? '0 : req_valid;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_rr_arbiter (
        .req         (arb_req),
        .ptr         (rr_ptr_reg),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    always_comb begin
        sel_req.addr = req_addr[grant_idx];
        sel_req.data = req_data[grant_idx];
    end

    // Zero-register writes complete the handshake but never reach the file.
    assign drop_write = (sel_req.addr == ADDR_W'(ZERO_REG));

    always_comb begin
        rr_ptr_next = rr_ptr_reg;
        if (grant_valid) begin
            rr_ptr_next = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg  <= '0;
            wr_en_reg   <= 1'b0;
            wr_sel_reg  <= '0;
            wr_data_reg <= '0;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
            wr_en_reg  <= grant_valid && !drop_write;
            if (grant_valid && !drop_write) begin
                wr_sel_reg  <= sel_req.addr;
                wr_data_reg <= sel_req.data;
            end
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_sel  = wr_sel_reg;
    assign wr_data = wr_data_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a reference round-robin model predicts
// each grant and the following write cycle; predictions are queued and compared.
module tb_regfile_wb_arbiter;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             wb_stall;
    logic [3:0]       req_valid;
    logic [3:0][4:0]  req_addr;
    logic [3:0][63:0] req_data;
    logic [3:0]       req_ready;
    logic             wr_en;
    logic [4:0]       wr_sel;
    logic [63:0]      wr_data;

    regfile_wb_arbiter #(
        .NUM_REQ  (4),
        .DATA_W   (64),
        .ADDR_W   (5),
        .ZERO_REG (31)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wb_stall  (wb_stall),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_sel    (wr_sel),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [4:0]  sel;
        logic [63:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          model_ptr;
    logic [4:0]  last_sel;
    logic [63:0] last_data;
    logic [4:0]  cur_addr [4];
    logic [63:0] cur_data [4];
    int          obs_cnt  [4];
    logic [3:0]  obs_ready;

    // Requesters must keep valid asserted until accepted.
    logic [3:0] pend_q = '0;
    always @(posedge clk) begin
        if (rst_n) assert ((req_valid & pend_q) == pend_q) else $error("valid dropped before acceptance");
        pend_q <= rst_n ? (req_valid & ~req_ready) : 4'b0;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic int model_grant(input int ptr, input logic [3:0] v, input logic stall);
        if (stall) return -1;
        for (int off = 0; off < 4; off++) begin
            if (v[(ptr + off) % 4]) return (ptr + off) % 4;
        end
        return -1;
    endfunction

    task automatic new_item(input int i);
        cur_addr[i] = 5'($urandom_range(0, 30));
        cur_data[i] = {$urandom, $urandom};
    endtask

    task automatic drive(input logic stall, input logic [3:0] vmask);
        wb_stall  = stall;
        req_valid = vmask;
        for (int i = 0; i < 4; i++) begin
            req_addr[i] = cur_addr[i];
            req_data[i] = cur_data[i];
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_ptr = 0;
        last_sel  = '0;
        last_data = '0;
    endtask

    // Called at a negedge; holds reset for one cycle and releases at the next negedge.
    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        check_val("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        check_val("rst_wr_en", 64'(wr_en), 64'd0);
        check_val("rst_wr_sel", 64'(wr_sel), 64'd0);
        check_val("rst_wr_data", wr_data, 64'd0);
        rst_n = 1'b1;
    endtask

    // One transaction cycle: drive at negedge, check ready, predict, check outputs next negedge.
    task automatic step(input logic stall, input logic [3:0] vmask);
        int         g;
        exp_t       e;
        logic [3:0] exp_ready;
        drive(stall, vmask);
        #1;
        g         = model_grant(model_ptr, vmask, stall);
        exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0;
        obs_ready = req_ready;
        check_val("ready", 64'(req_ready), 64'(exp_ready));
        for (int i = 0; i < 4; i++) if (req_ready[i]) obs_cnt[i]++;
        e.en = 1'b0;
        if (g >= 0) begin
            if (cur_addr[g] != 5'd31) begin
                last_sel  = cur_addr[g];
                last_data = cur_data[g];
                e.en      = 1'b1;
            end
            model_ptr = (g + 1) % 4;
        end
        e.sel  = last_sel;
        e.data = last_data;
        exp_q.push_back(e);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            check_val("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check_val("wr_en", 64'(wr_en), 64'(e.en));
            check_val("wr_sel", 64'(wr_sel), 64'(e.sel));
            check_val("wr_data", wr_data, e.data);
        end
        $display("txn t=%0t stall=%b valid=%b ready=%b wr_en=%b wr_sel=%0d wr_data=%h",
                 $time, stall, vmask, obs_ready, wr_en, wr_sel, wr_data);
        if (g >= 0) new_item(g);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          g;
        logic [31:0] dec;
        for (int i = 0; i < 4; i++) new_item(i);
        rst_n = 1'b0;
        drive(1'b0, 4'hF);
        @(negedge clk);

        // Reset with all requesters valid, then first grant goes to req0
        do_reset();
        for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
        step(1'b0, 4'hF);
        check_val("t1_first", 64'(obs_ready), 64'h1);

        // Continuous traffic: strict rotation, one write per cycle
        for (int i = 0; i < 4; i++) obs_cnt[i] = 0;
        for (int n = 0; n < 16; n++) step(1'b0, 4'hF);
        for (int i = 0; i < 4; i++) check_val($sformatf("t3_share%0d", i), 64'(obs_cnt[i]), 64'd4);

        // Single source with a decoder view of the write port
        @(negedge clk);
        do_reset();
        cur_addr[2] = 5'd5;
        cur_data[2] = 64'hABCD;
        step(1'b0, 4'b0100);
        dec = wr_en ? (32'h1 << wr_sel) : 32'h0;
        check_val("t2_decode", 64'(dec), 64'h20);
        step(1'b0, 4'b0000);

        // Zero-register write is consumed silently, then req3 writes r7
        do_reset();
        cur_addr[1] = 5'd31;
        cur_data[1] = 64'h1111_2222_3333_4444;
        cur_addr[3] = 5'd7;
        cur_data[3] = 64'h5555_6666_7777_8888;
        step(1'b0, 4'b1010);
        check_val("t4_first", 64'(obs_ready), 64'h2);
        step(1'b0, 4'b1000);
        check_val("t4_second", 64'(obs_ready), 64'h8);

        // Stall freezes grants and pointer; resumes at the held pointer
        step(1'b0, 4'hF);
        for (int n = 0; n < 3; n++) step(1'b1, 4'hF);
        step(1'b0, 4'hF);
        check_val("t5_resume", 64'(obs_ready), 64'h2);

        // Reset asserted in the write cycle kills the output immediately
        drive(1'b0, 4'hF);
        #1;
        g = model_grant(model_ptr, 4'hF, 1'b0);
        check_val("t6_ready", 64'(req_ready), 64'(4'(1 << g)));
        @(posedge clk);
        #1;
        check_val("t6_wr_en_pre", 64'(wr_en), 64'(cur_addr[g] != 5'd31));
        rst_n = 1'b0;
        #1;
        check_val("t6_wr_en_rst", 64'(wr_en), 64'd0);
        check_val("t6_wr_sel_rst", 64'(wr_sel), 64'd0);
        check_val("t6_wr_data_rst", wr_data, 64'd0);
        check_val("t6_ready_rst", 64'(req_ready), 64'd0);
        new_item(g);
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 4'hF);
        check_val("t6_restart", 64'(obs_ready), 64'h1);
        step(1'b0, 4'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
